// File: rtl/gecko_register_scoreboard_pkg.sv
// Shared types for the gecko register scoreboard: writeback operation,
// ordering tag and scoreboard lifecycle state.
package gecko_register_scoreboard_pkg;

  typedef logic [1:0] gecko_reg_status_t;

  typedef struct packed {
    logic [4:0]        addr;
    logic [31:0]       value;
    gecko_reg_status_t reg_status;
  } gecko_operation_t;

  typedef enum logic {
    INIT,
    RUN
  } gecko_scoreboard_state_t;

endpackage

// File: rtl/std_distributed_ram.sv
// Distributed RAM: one synchronous write port, READ_PORTS asynchronous read ports.
module std_distributed_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned READ_PORTS = 1
) (
  input  logic                                  clk,
  input  logic                                  write_enable,
  input  logic [ADDR_WIDTH-1:0]                 write_addr,
  input  logic [DATA_WIDTH-1:0]                 write_data,
  input  logic [READ_PORTS-1:0][ADDR_WIDTH-1:0] read_addr,
  output logic [READ_PORTS-1:0][DATA_WIDTH-1:0] read_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (write_enable) mem[write_addr] <= write_data;
  end

  always_comb begin
    for (int unsigned i = 0; i < READ_PORTS; i++) read_data[i] = mem[read_addr[i]];
  end

endmodule

// File: rtl/gecko_register_scoreboard.sv
// Register file with per-register issue/retire tag counters that enforce
// in-order writeback and report busy operands to decode.
module gecko_register_scoreboard
  import gecko_register_scoreboard_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned STATUS_WIDTH = $bits(gecko_reg_status_t),
  parameter int unsigned BYPASS       = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_valid,
  output logic                    wb_ready,
  input  gecko_operation_t        wb_payload,
  input  logic [ADDR_WIDTH-1:0]   rs1_addr,
  input  logic [ADDR_WIDTH-1:0]   rs2_addr,
  output logic [DATA_WIDTH-1:0]   rs1_value,
  output logic [DATA_WIDTH-1:0]   rs2_value,
  output logic                    rs1_busy,
  output logic                    rs2_busy,
  input  logic                    reserve_valid,
  input  logic [ADDR_WIDTH-1:0]   reserve_addr,
  output logic                    reserve_ready,
  output logic [STATUS_WIDTH-1:0] reserve_status,
  output logic                    init_done,
  output logic                    order_error
);

  localparam logic [STATUS_WIDTH-1:0] TAG_ONE  = STATUS_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0]   ADDR_ONE = ADDR_WIDTH'(1);

  gecko_scoreboard_state_t state, state_next;
  logic [ADDR_WIDTH-1:0]   sweep;

  logic [ADDR_WIDTH-1:0]   wb_addr;
  logic [DATA_WIDTH-1:0]   wb_value;
  logic [STATUS_WIDTH-1:0] wb_tag, wb_tag_next;
  logic                    wb_fire, tag_ok, commit, reserve_fire;
  logic                    hit1, hit2;

  logic [1:0][DATA_WIDTH-1:0]   rf_rd;
  logic [2:0][STATUS_WIDTH-1:0] iss_rd;
  logic [3:0][STATUS_WIDTH-1:0] ret_rd;

  logic                    rf_we, iss_we, ret_we;
  logic [ADDR_WIDTH-1:0]   rf_waddr, iss_waddr, ret_waddr;
  logic [DATA_WIDTH-1:0]   rf_wdata;
  logic [STATUS_WIDTH-1:0] iss_wdata, ret_wdata;

  assign wb_addr      = wb_payload.addr[ADDR_WIDTH-1:0];
  assign wb_value     = wb_payload.value[DATA_WIDTH-1:0];
  assign wb_tag       = wb_payload.reg_status[STATUS_WIDTH-1:0];
  assign wb_tag_next  = wb_tag + TAG_ONE;
  assign wb_fire      = wb_valid && wb_ready;
  assign tag_ok       = (wb_tag == ret_rd[3]);
  assign commit       = wb_fire && (wb_addr != '0) && tag_ok;
  assign reserve_fire = reserve_valid && reserve_ready;

  std_distributed_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .READ_PORTS(2)) regfile (
    .clk(clk), .write_enable(rf_we), .write_addr(rf_waddr), .write_data(rf_wdata),
    .read_addr({rs2_addr, rs1_addr}), .read_data(rf_rd)
  );

  std_distributed_ram #(.DATA_WIDTH(STATUS_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .READ_PORTS(3)) issue (
    .clk(clk), .write_enable(iss_we), .write_addr(iss_waddr), .write_data(iss_wdata),
    .read_addr({reserve_addr, rs2_addr, rs1_addr}), .read_data(iss_rd)
  );

  std_distributed_ram #(.DATA_WIDTH(STATUS_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .READ_PORTS(4)) retired (
    .clk(clk), .write_enable(ret_we), .write_addr(ret_waddr), .write_data(ret_wdata),
    .read_addr({wb_addr, reserve_addr, rs2_addr, rs1_addr}), .read_data(ret_rd)
  );

  // During INIT the sweep owns all three write ports and zeroes one entry per cycle.
  always_comb begin
    rf_we     = commit;
    rf_waddr  = wb_addr;
    rf_wdata  = wb_value;
    iss_we    = reserve_fire && (reserve_addr != '0);
    iss_waddr = reserve_addr;
    iss_wdata = iss_rd[2] + TAG_ONE;
    ret_we    = commit;
    ret_waddr = wb_addr;
    ret_wdata = wb_tag_next;
    if (state == INIT) begin
      rf_we     = 1'b1;
      rf_waddr  = sweep;
      rf_wdata  = '0;
      iss_we    = 1'b1;
      iss_waddr = sweep;
      iss_wdata = '0;
      ret_we    = 1'b1;
      ret_waddr = sweep;
      ret_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INIT;
      sweep       <= '0;
      order_error <= 1'b0;
    end else begin
      state <= state_next;
      if (state == INIT) sweep <= sweep + ADDR_ONE;
      if (wb_fire && (wb_addr != '0) && !tag_ok) order_error <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    if (state == INIT && sweep == '1) state_next = RUN;
  end

  // reserve_ready reads the stored retired[] only, keeping wb off its timing path.
  always_comb begin
    wb_ready       = (state == RUN);
    init_done      = (state == RUN);
    reserve_ready  = (state == RUN) &&
                     ((reserve_addr == '0) || ((iss_rd[2] + TAG_ONE) != ret_rd[2]));
    reserve_status = (reserve_addr == '0) ? '0 : iss_rd[2];
  end

  always_comb begin
    hit1      = (BYPASS != 0) && commit && (wb_addr == rs1_addr);
    hit2      = (BYPASS != 0) && commit && (wb_addr == rs2_addr);
    rs1_value = hit1 ? wb_value : rf_rd[0];
    rs2_value = hit2 ? wb_value : rf_rd[1];
    rs1_busy  = hit1 ? (iss_rd[0] != wb_tag_next) : (iss_rd[0] != ret_rd[0]);
    rs2_busy  = hit2 ? (iss_rd[1] != wb_tag_next) : (iss_rd[1] != ret_rd[1]);
    if (rs1_addr == '0) begin
      rs1_value = '0;
      rs1_busy  = 1'b0;
    end
    if (rs2_addr == '0) begin
      rs2_value = '0;
      rs2_busy  = 1'b0;
    end
  end

endmodule

// File: tb/tb_gecko_register_scoreboard.sv
// Scoreboard bench for gecko_register_scoreboard: expectations are queued as
// stimulus is driven and retired against sampled DUT outputs per scenario.
module tb_gecko_register_scoreboard;
  import gecko_register_scoreboard_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             wb_valid, wb_ready;
  gecko_operation_t wb_payload;
  logic [4:0]       rs1_addr, rs2_addr, reserve_addr;
  logic [31:0]      rs1_value, rs2_value;
  logic             rs1_busy, rs2_busy;
  logic             reserve_valid, reserve_ready;
  logic [1:0]       reserve_status;
  logic             init_done, order_error;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  gecko_register_scoreboard #(
    .DATA_WIDTH(32), .ADDR_WIDTH(5), .STATUS_WIDTH(2), .BYPASS(1)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_payload(wb_payload),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_value(rs1_value), .rs2_value(rs2_value),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .reserve_valid(reserve_valid), .reserve_addr(reserve_addr),
    .reserve_ready(reserve_ready), .reserve_status(reserve_status),
    .init_done(init_done), .order_error(order_error)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    wb_valid      = 1'b0;
    wb_payload    = '0;
    reserve_valid = 1'b0;
    reserve_addr  = '0;
  endtask

  task automatic expect_val(input string name, input logic [31:0] value);
    name_q.push_back(name);
    exp_q.push_back(value);
  endtask

  task automatic sample(input logic [31:0] value);
    obs_q.push_back(value);
  endtask

  task automatic drive_wb(input logic [4:0] a, input logic [31:0] v, input logic [1:0] t);
    wb_valid   = 1'b1;
    wb_payload = '{addr: a, value: v, reg_status: t};
  endtask

  // Reset pulse, then count cycles until init_done, capped at 40.
  task automatic reset_and_sweep(input string tag);
    int unsigned cycles;
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    expect_val({tag, "_init_done_low"}, 0);   sample(init_done);
    expect_val({tag, "_order_error_low"}, 0); sample(order_error);
    cycles = 0;
    for (int unsigned i = 1; i <= 40; i++) begin
      step();
      #1;
      if (!init_done && (wb_ready || reserve_ready)) begin
        expect_val({tag, "_ready_during_init"}, 0);
        sample(1);
      end
      if (init_done) begin
        cycles = i;
        break;
      end
    end
    expect_val({tag, "_init_cycles"}, 32); sample(cycles);
  endtask

  task automatic retire_checks(input string scen);
    string       n;
    logic [31:0] e, o;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      o = (obs_q.size() != 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL %s/%s: got %h expected %h", scen, n, o, e);
      end
    end
    obs_q.delete();
  endtask

  task automatic test_reset();
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;
    reset_and_sweep("reset");
    rs1_addr = 5'd5;
    rs2_addr = 5'd9;
    #1;
    expect_val("rs1_value", 0); sample(rs1_value);
    expect_val("rs1_busy", 0);  sample(rs1_busy);
    expect_val("rs2_value", 0); sample(rs2_value);
    expect_val("rs2_busy", 0);  sample(rs2_busy);
    expect_val("wb_ready", 1);  sample(wb_ready);
    retire_checks("test_reset");
  endtask

  task automatic test_reserve_retire();
    rs1_addr      = 5'd5;
    reserve_valid = 1'b1;
    reserve_addr  = 5'd5;
    #1;
    expect_val("reserve_ready", 1);   sample(reserve_ready);
    expect_val("reserve_status", 0);  sample(reserve_status);
    expect_val("busy_same_cycle", 0); sample(rs1_busy);
    step();
    idle();
    #1;
    expect_val("busy_next_cycle", 1); sample(rs1_busy);
    drive_wb(5'd5, 32'hDEAD_BEEF, 2'd0);
    step();
    idle();
    #1;
    expect_val("value_after_wb", 32'hDEAD_BEEF); sample(rs1_value);
    expect_val("busy_after_wb", 0);              sample(rs1_busy);
    expect_val("order_error", 0);                sample(order_error);
    retire_checks("test_reserve_retire");
  endtask

  task automatic test_x0();
    rs1_addr      = 5'd0;
    reserve_valid = 1'b1;
    reserve_addr  = 5'd0;
    #1;
    expect_val("x0_reserve_ready", 1);  sample(reserve_ready);
    expect_val("x0_reserve_status", 0); sample(reserve_status);
    step();
    idle();
    #1;
    expect_val("x0_busy", 0); sample(rs1_busy);
    drive_wb(5'd0, 32'h0000_1234, 2'd3);
    step();
    idle();
    #1;
    expect_val("x0_value", 0);             sample(rs1_value);
    expect_val("x0_no_order_error", 0);    sample(order_error);
    reserve_addr = 5'd0;
    #1;
    expect_val("x0_status_after", 0);      sample(reserve_status);
    retire_checks("test_x0");
  endtask

  task automatic test_saturation();
    rs1_addr      = 5'd7;
    reserve_valid = 1'b1;
    reserve_addr  = 5'd7;
    for (int unsigned i = 0; i < 3; i++) begin
      #1;
      expect_val($sformatf("sat_ready_%0d", i), 1);  sample(reserve_ready);
      expect_val($sformatf("sat_status_%0d", i), i); sample(reserve_status);
      step();
    end
    #1;
    expect_val("sat_full_ready", 0); sample(reserve_ready);
    drive_wb(5'd7, 32'h0000_0077, 2'd0);
    #1;
    expect_val("sat_no_wb_path", 0); sample(reserve_ready);
    step();
    wb_valid = 1'b0;
    #1;
    expect_val("sat_ready_after_retire", 1);  sample(reserve_ready);
    expect_val("sat_status_after_retire", 3); sample(reserve_status);
    expect_val("sat_value", 32'h77);          sample(rs1_value);
    expect_val("sat_busy", 1);                sample(rs1_busy);
    idle();
    retire_checks("test_saturation");
  endtask

  task automatic test_order_error();
    rs1_addr      = 5'd8;
    reserve_valid = 1'b1;
    reserve_addr  = 5'd8;
    step();
    step();
    idle();
    #1;
    expect_val("ord_before", 0); sample(order_error);
    drive_wb(5'd8, 32'h0000_0BAD, 2'd1);
    step();
    idle();
    #1;
    expect_val("ord_set", 1);        sample(order_error);
    expect_val("ord_value_kept", 0); sample(rs1_value);
    expect_val("ord_busy", 1);       sample(rs1_busy);
    drive_wb(5'd8, 32'h0000_0088, 2'd0);
    step();
    idle();
    step();
    #1;
    expect_val("ord_good_value", 32'h88); sample(rs1_value);
    expect_val("ord_sticky", 1);          sample(order_error);
    retire_checks("test_order_error");
  endtask

  task automatic test_bypass();
    reserve_valid = 1'b1;
    reserve_addr  = 5'd3;
    step();
    idle();
    rs2_addr = 5'd3;
    #1;
    expect_val("byp_pre_busy", 1);  sample(rs2_busy);
    expect_val("byp_pre_value", 0); sample(rs2_value);
    drive_wb(5'd3, 32'h0000_0055, 2'd0);
    #1;
    expect_val("byp_value", 32'h55); sample(rs2_value);
    expect_val("byp_busy", 0);       sample(rs2_busy);
    step();
    idle();
    reserve_valid = 1'b1;
    reserve_addr  = 5'd4;
    step();
    step();
    idle();
    rs1_addr = 5'd4;
    drive_wb(5'd4, 32'h0000_0066, 2'd0);
    #1;
    expect_val("byp2_value", 32'h66); sample(rs1_value);
    expect_val("byp2_busy", 1);       sample(rs1_busy);
    step();
    idle();
    retire_checks("test_bypass");
  endtask

  task automatic test_mid_reset();
    rs1_addr      = 5'd9;
    reserve_valid = 1'b1;
    reserve_addr  = 5'd9;
    step();
    step();
    idle();
    #1;
    expect_val("mid_busy_before", 1); sample(rs1_busy);
    reset_and_sweep("mid");
    rs1_addr     = 5'd9;
    rs2_addr     = 5'd5;
    reserve_addr = 5'd9;
    #1;
    expect_val("mid_busy_after", 0);     sample(rs1_busy);
    expect_val("mid_status_after", 0);   sample(reserve_status);
    expect_val("mid_regfile_clear", 0);  sample(rs2_value);
    expect_val("mid_order_cleared", 0);  sample(order_error);
    retire_checks("test_mid_reset");
  endtask

  initial begin
    idle();
    rst      = 1'b1;
    rs1_addr = '0;
    rs2_addr = '0;
    test_reset();
    test_reserve_retire();
    test_x0();
    test_saturation();
    test_order_error();
    test_bypass();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
